// File: rtl/count_controller.sv
// rtl/count_controller.sv - prescaled up/down/bounce/one-shot count controller with run/pause/step FSM
module count_controller #(
  parameter int CNT_W = 4,
  parameter int PRE_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       s,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             ud,
  output logic [1:0]       state,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] M_UP     = 2'd0;
  localparam logic [1:0] M_DOWN   = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ud_q, ud_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       mode_q, mode_d;
  logic [4:0]       s_q, s_d;

  logic [PRE_W-1:0] pre_max;
  logic             pre_en;
  logic             adv;

  // Next-state: FSM commands first, then prescaler counting, then the advance itself
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ud_d    = ud_q;
    pre_d   = pre_q;
    mode_d  = mode_q;
    s_d     = s_q;
    tick_d  = 1'b0;
    pre_en  = 1'b0;
    adv     = 1'b0;
    pre_max = (PRE_ONE << s_q) - PRE_ONE;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          s_d     = s;
          pre_d   = '0;
          cnt_d   = (mode == M_DOWN) ? CNT_ONES : '0;
          ud_d    = (mode != M_DOWN);
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else begin
          pre_en = 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          pre_d   = '0;
          ud_d    = 1'b1;
        end else if (start) begin
          // The resume edge is already a counting cycle, continuing from the held prescaler
          state_d = RUN;
          pre_en  = 1'b1;
        end else if (step) begin
          adv = 1'b1;
        end
      end
      default: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          pre_d   = '0;
          ud_d    = 1'b1;
        end else if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          pre_d   = '0;
          s_d     = s;
        end
      end
    endcase

    if (pre_en) begin
      if (pre_q == pre_max) begin
        pre_d = '0;
        adv   = 1'b1;
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end

    if (adv) begin
      tick_d = 1'b1;
      s_d    = s;
      case (mode_q)
        M_UP:   cnt_d = cnt_q + CNT_ONE;
        M_DOWN: cnt_d = cnt_q - CNT_ONE;
        M_BOUNCE: begin
          if (ud_q) begin
            if (cnt_q == CNT_ONES) begin
              ud_d  = 1'b0;
              cnt_d = CNT_ONES - CNT_ONE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            if (cnt_q == '0) begin
              ud_d  = 1'b1;
              cnt_d = CNT_ONE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_ONES - CNT_ONE) begin
            state_d = DONE;
          end
        end
      endcase
    end

    done_d = (state_d == DONE);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ud_q    <= 1'b1;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      mode_q  <= 2'd0;
      s_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ud_q    <= ud_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      s_q     <= s_d;
    end
  end

  assign cnt   = cnt_q;
  assign tick  = tick_q;
  assign ud    = ud_q;
  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_count_controller.sv
// tb/tb_count_controller.sv - self-checking bench for count_controller
module tb_count_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] s = 5'd0;
  logic [1:0] mode = 2'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic [3:0] cnt;
  logic       tick;
  logic       ud;
  logic [1:0] state;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;

  count_controller #(.CNT_W(4), .PRE_W(32)) dut (
    .clk(clk), .rst(rst), .s(s), .mode(mode),
    .start(start), .stop(stop), .step(step),
    .cnt(cnt), .tick(tick), .ud(ud), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: states 0 idle, 1 run, 2 pause, 3 done
  localparam int MAXV = 15;
  int     m_state, m_cnt, m_mode, m_s;
  bit     m_ud, m_tick;
  longint m_pre;

  task automatic m_advance(input int s_in);
    m_tick = 1;
    m_s = s_in;
    case (m_mode)
      0: m_cnt = (m_cnt + 1) % (MAXV + 1);
      1: m_cnt = (m_cnt + MAXV) % (MAXV + 1);
      2: begin
        if (m_ud) begin
          if (m_cnt == MAXV) begin m_ud = 0; m_cnt = MAXV - 1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_ud = 1; m_cnt = 1; end
          else m_cnt = m_cnt - 1;
        end
      end
      default: begin
        m_cnt = m_cnt + 1;
        if (m_cnt == MAXV) m_state = 3;
      end
    endcase
  endtask

  task automatic m_count(input int s_in);
    if (m_pre == (longint'(1) << m_s) - 1) begin
      m_pre = 0;
      m_advance(s_in);
    end else begin
      m_pre = m_pre + 1;
    end
  endtask

  task automatic m_update(input bit rn, input bit st, input bit sp, input bit sk,
                          input int s_in, input int mode_in);
    m_tick = 0;
    if (!rn) begin
      m_state = 0; m_cnt = 0; m_ud = 1; m_pre = 0; m_mode = 0; m_s = 0;
    end else if (m_state == 0) begin
      if (st && !sp) begin
        m_state = 1; m_mode = mode_in; m_s = s_in; m_pre = 0;
        m_cnt = (mode_in == 1) ? MAXV : 0;
        m_ud = (mode_in != 1);
      end
    end else if (m_state == 1) begin
      if (sp) m_state = 2;
      else m_count(s_in);
    end else if (m_state == 2) begin
      if (sp) begin m_state = 0; m_cnt = 0; m_pre = 0; m_ud = 1; end
      else if (st) begin m_state = 1; m_count(s_in); end
      else if (sk) m_advance(s_in);
    end else begin
      if (sp) begin m_state = 0; m_cnt = 0; m_pre = 0; m_ud = 1; end
      else if (st) begin m_state = 1; m_cnt = 0; m_pre = 0; m_s = s_in; end
    end
  endtask

  // One clock with the given command pulses; outputs are sampled 1 time unit after the edge
  task automatic cyc(input logic st, input logic sp, input logic sk, input logic rn);
    start = st; stop = sp; step = sk; rst = rn;
    @(posedge clk);
    #1;
    m_update(rn, st, sp, sk, int'(s), int'(mode));
    start = 1'b0; stop = 1'b0; step = 1'b0; rst = 1'b1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%0b exp=0", tick); end
    n_checks++; if (ud !== 1'b1) begin n_fail++; $display("FAIL reset_ud got=%0b exp=1", ud); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
  endtask

  task automatic test_mode0_wrap();
    int ticks;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    mode = 2'd0; s = 5'd2;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    ticks = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      ticks += int'(tick);
      n_checks++;
      if (tick !== ((i % 4) == 0)) begin n_fail++; $display("FAIL wrap_tick i=%0d got=%0b exp=%0b", i, tick, (i % 4) == 0); end
      n_checks++;
      if (cnt !== 4'((i / 4) % 16)) begin n_fail++; $display("FAIL wrap_cnt i=%0d got=%0d exp=%0d", i, cnt, (i / 4) % 16); end
    end
    n_checks++; if (ticks != 16) begin n_fail++; $display("FAIL wrap_tick_count got=%0d exp=16", ticks); end
    n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_final_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_bounce();
    int km, exp_cnt;
    bit exp_ud;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    mode = 2'd2; s = 5'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if (cnt !== 4'd0 || ud !== 1'b1) begin n_fail++; $display("FAIL bounce_start got=%0d/%0b exp=0/1", cnt, ud); end
    for (int k = 1; k <= 32; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      km = k % 30;
      exp_cnt = (km <= 15) ? km : 30 - km;
      exp_ud = (km >= 1 && km <= 15);
      n_checks++;
      if (cnt !== 4'(exp_cnt)) begin n_fail++; $display("FAIL bounce_cnt k=%0d got=%0d exp=%0d", k, cnt, exp_cnt); end
      n_checks++;
      if (ud !== exp_ud) begin n_fail++; $display("FAIL bounce_ud k=%0d got=%0b exp=%0b", k, ud, exp_ud); end
      n_checks++;
      if (tick !== 1'b1) begin n_fail++; $display("FAIL bounce_tick k=%0d got=%0b exp=1", k, tick); end
    end
  endtask

  task automatic test_oneshot();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    mode = 2'd3; s = 5'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (cnt !== 4'(k) || tick !== 1'b1) begin n_fail++; $display("FAIL oneshot_cnt k=%0d got=%0d/%0b exp=%0d/1", k, cnt, tick, k); end
      n_checks++;
      if (state !== ((k == 15) ? 2'd3 : 2'd1)) begin n_fail++; $display("FAIL oneshot_state k=%0d got=%0d", k, state); end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL oneshot_done got=%0b exp=1", done); end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, (k == 2), 1'b1);
      n_checks++;
      if (tick !== 1'b0 || cnt !== 4'd15 || state !== 2'd3) begin
        n_fail++; $display("FAIL oneshot_hold k=%0d got=%0b/%0d/%0d exp=0/15/3", k, tick, cnt, state);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (state !== 2'd1 || cnt !== 4'd0 || done !== 1'b0 || tick !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_restart got=%0d/%0d/%0b exp=1/0/0", state, cnt, done);
    end
  endtask

  task automatic test_pause_step();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    mode = 2'd0; s = 5'd3;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 13; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++; if (state !== 2'd2 || cnt !== 4'd1) begin n_fail++; $display("FAIL pause_enter got=%0d/%0d exp=2/1", state, cnt); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (tick !== 1'b0 || cnt !== 4'd1) begin n_fail++; $display("FAIL pause_hold got=%0b/%0d exp=0/1", tick, cnt); end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (tick !== 1'b1 || cnt !== 4'd2 || state !== 2'd2) begin n_fail++; $display("FAIL pause_step got=%0b/%0d/%0d exp=1/2/2", tick, cnt, state); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL pause_step_single got=%0b exp=0", tick); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if (state !== 2'd1 || tick !== 1'b0) begin n_fail++; $display("FAIL resume got=%0d/%0b exp=1/0", state, tick); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL resume_early got=%0b exp=0", tick); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (tick !== 1'b1 || cnt !== 4'd3) begin n_fail++; $display("FAIL resume_tick got=%0b/%0d exp=1/3", tick, cnt); end
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++; if (state !== 2'd0 || cnt !== 4'd0 || ud !== 1'b1) begin n_fail++; $display("FAIL stop_idle got=%0d/%0d/%0b exp=0/0/1", state, cnt, ud); end
  endtask

  task automatic test_cmds_and_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    mode = 2'd0; s = 5'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (cnt !== 4'd9 || state !== 2'd1) begin n_fail++; $display("FAIL run_to_9 got=%0d/%0d exp=9/1", cnt, state); end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (state !== 2'd0 || cnt !== 4'd0 || tick !== 1'b0 || ud !== 1'b1) begin
      n_fail++; $display("FAIL mid_run_reset got=%0d/%0d/%0b/%0b exp=0/0/0/1", state, cnt, tick, ud);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++; if (state !== 2'd2 || cnt !== 4'd3 || tick !== 1'b0) begin n_fail++; $display("FAIL start_stop got=%0d/%0d/%0b exp=2/3/0", state, cnt, tick); end
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    mode = 2'd1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if (cnt !== 4'd15 || ud !== 1'b0) begin n_fail++; $display("FAIL down_start got=%0d/%0b exp=15/0", cnt, ud); end
    mode = 2'd0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (cnt !== 4'd13 || tick !== 1'b1) begin n_fail++; $display("FAIL down_mode_locked got=%0d/%0b exp=13/1", cnt, tick); end
  endtask

  task automatic test_random();
    int r;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) s = 5'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 199);
      cyc(r < 20, (r >= 15 && r < 32), (r >= 32 && r < 70), (r != 199));
      n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state i=%0d got=%0d exp=%0d", i, state, m_state); end
      n_checks++; if (cnt !== 4'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, cnt, m_cnt); end
      n_checks++; if (tick !== m_tick) begin n_fail++; $display("FAIL rnd_tick i=%0d got=%0b exp=%0b", i, tick, m_tick); end
      n_checks++; if (ud !== m_ud) begin n_fail++; $display("FAIL rnd_ud i=%0d got=%0b exp=%0b", i, ud, m_ud); end
      n_checks++; if (done !== (m_state == 3)) begin n_fail++; $display("FAIL rnd_done i=%0d got=%0b exp=%0b", i, done, m_state == 3); end
    end
  endtask

  initial begin
    m_update(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    test_reset();
    test_mode0_wrap();
    test_bounce();
    test_oneshot();
    test_pause_step();
    test_cmds_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
